// File: rtl/dcache_axi_bridge_if.sv
// Cache-side request/response handshake and the AXI4 read/write channels of the bridge.
// The master modport is the bridge's view; slave is the cache + AXI memory side.
interface dcache_axi_bridge_if #(
  parameter int ID_WIDTH = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_addr;
  logic                write_en;
  logic [127:0]        req_Wdata;
  logic                res_valid;
  logic                res_ready;
  logic [127:0]        res_Rdata;
  logic [1:0]          axi_Wdone;

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    input  req_valid, req_addr, write_en, req_Wdata, res_ready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid,
    output req_ready, res_valid, res_Rdata, axi_Wdone,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output req_valid, req_addr, write_en, req_Wdata, res_ready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid,
    input  req_ready, res_valid, res_Rdata, axi_Wdone,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI4 bridge: one 4-beat INCR write-back or line-fill burst in flight at a time.
// Every AXI output comes from registered state, so no cache or ready input reaches a valid combinationally.
module dcache_axi_bridge #(
  parameter int AXI_ID   = 0,
  parameter int ID_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  dcache_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    W_AW,
    W_DATA,
    W_RESP,
    R_AR,
    R_DATA,
    R_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    cnt;
  logic [31:0]   addr_q;
  logic [127:0]  data_q;
  logic [127:0]  rdata_q;
  logic          done;
  logic          unused_ok;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = bus.write_en ? W_AW : R_AR;
      W_AW:    if (bus.awready) state_nx = W_DATA;
      W_DATA:  if (bus.wready && cnt == 2'd3) state_nx = W_RESP;
      W_RESP:  if (bus.bvalid) state_nx = IDLE;
      R_AR:    if (bus.arready) state_nx = R_DATA;
      R_DATA:  if (bus.rvalid && (cnt == 2'd3 || bus.rlast)) state_nx = R_DONE;
      R_DONE:  if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A fill clears the line buffer on accept so words skipped by an early rlast read back as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q <= {bus.req_addr[31:4], 4'h0};
          data_q <= bus.req_Wdata;
          cnt    <= '0;
          if (!bus.write_en) rdata_q <= '0;
        end
        W_AW:   if (bus.awready) cnt <= '0;
        W_DATA: if (bus.wready) cnt <= cnt + 2'd1;
        R_AR:   if (bus.arready) cnt <= '0;
        R_DATA: if (bus.rvalid) begin
          rdata_q[{cnt, 5'd0} +: 32] <= bus.rdata;
          cnt                        <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Control outputs are qualified by rst so they read zero for the whole time reset is held.
  assign bus.req_ready = rst && (state == IDLE);
  assign bus.res_valid = rst && (state == R_DONE);
  assign bus.res_Rdata = rdata_q;

  assign bus.arid    = ID_WIDTH'(AXI_ID);
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd3;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arvalid = rst && (state == R_AR);
  assign bus.rready  = rst && (state == R_DATA);

  assign bus.awid    = ID_WIDTH'(AXI_ID);
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 8'd3;
  assign bus.awsize  = 3'b010;
  assign bus.awburst = 2'b01;
  assign bus.awvalid = rst && (state == W_AW);

  assign bus.wdata  = data_q[{cnt, 5'd0} +: 32];
  assign bus.wstrb  = 4'hF;
  assign bus.wvalid = rst && (state == W_DATA);
  assign bus.wlast  = rst && (state == W_DATA) && (cnt == 2'd3);
  assign bus.bready = rst && (state == W_RESP);

  assign done          = rst && (state == W_RESP) && bus.bvalid;
  assign bus.axi_Wdone = {done && (bus.bresp != 2'b00), done};

  assign unused_ok = ^{bus.rid, bus.rresp, bus.bid, bus.req_addr[3:0]};

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: directed vector table, randomized transactions
// against a transaction-level model, and hand-written dirty-miss and mid-burst reset sequences.
module tb_dcache_axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dcache_axi_bridge_if #(.ID_WIDTH(4)) bus ();

  dcache_axi_bridge #(.AXI_ID(5), .ID_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rbeats;
    int           nbeats;
    bit           last_final;
    logic [1:0]   bresp;
    int           dly;
    logic [31:0]  exp_addr;
    logic [127:0] exp_rdata;
    logic [1:0]   exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: line address and the fill line the cache should see after n beats.
  function automatic logic [31:0] model_line_addr(input logic [31:0] a);
    return a - (a % 32'd16);
  endfunction

  function automatic logic [127:0] model_fill(input logic [127:0] beats, input int n);
    logic [127:0] mask;
    mask = (n >= 4) ? '1 : ((128'd1 << (32 * n)) - 128'd1);
    return beats & mask;
  endfunction

  task automatic wait_accept(output int t);
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", bus.req_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_fill(input logic [31:0] addr, input logic [127:0] beats, input int n,
                          input bit last_final, input int dly, input logic [31:0] exp_addr,
                          input logic [127:0] exp_rdata, input bit pre_valid);
    int t;
    if (!pre_valid) begin
      bus.req_addr  = addr;
      bus.write_en  = 1'b0;
      bus.req_Wdata = {$urandom, $urandom, $urandom, $urandom};
      bus.req_valid = 1'b1;
    end
    wait_accept(t);
    if (pre_valid) chk("dirty_accept_wait", t, 0);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    chk("ar_fields", {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst},
        {1'b1, 4'd5, exp_addr, 8'd3, 3'b010, 2'b01});
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, exp_addr});
    end
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    chk("ar_done_rready", {bus.arvalid, bus.rready}, 2'b01);
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < dly; d++) begin
        chk("r_wait", {bus.rready, bus.res_valid}, 2'b10);
        @(negedge clk);
      end
      bus.rvalid = 1'b1;
      bus.rdata  = beats[32*i +: 32];
      bus.rlast  = (i == n - 1) && (n < 4 || last_final);
      bus.rid    = 4'($urandom);
      bus.rresp  = 2'($urandom);
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rdata  = $urandom;
    end
    t = 0;
    while (!bus.res_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid", {bus.res_valid, bus.rready}, 2'b10);
    chk("res_Rdata", bus.res_Rdata, exp_rdata);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk("res_hold_valid", bus.res_valid, 1'b1);
      chk("res_hold_data", bus.res_Rdata, exp_rdata);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("fill_idle", {bus.res_valid, bus.req_ready}, 2'b01);
  endtask

  task automatic run_wb(input logic [31:0] addr, input logic [127:0] data, input logic [1:0] bresp,
                        input int dly, input logic [31:0] exp_addr, input logic [1:0] exp_done,
                        input bit keep_next, input logic [31:0] next_addr);
    int t;
    bus.req_addr  = addr;
    bus.write_en  = 1'b1;
    bus.req_Wdata = data;
    bus.req_valid = 1'b1;
    wait_accept(t);
    if (keep_next) begin
      bus.write_en = 1'b0;
      bus.req_addr = next_addr;
    end else begin
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
    end
    bus.req_Wdata = {$urandom, $urandom, $urandom, $urandom};
    chk("aw_fields", {bus.awvalid, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
        {1'b1, 4'd5, exp_addr, 8'd3, 3'b010, 2'b01});
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk("aw_hold", {bus.awvalid, bus.awaddr, bus.req_ready}, {1'b1, exp_addr, 1'b0});
    end
    bus.awready = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < dly; d++) begin
        chk("w_hold", {bus.wvalid, bus.wdata}, {1'b1, data[32*i +: 32]});
        @(negedge clk);
      end
      chk("w_beat", {bus.wvalid, bus.wlast, bus.wstrb, bus.wdata},
          {1'b1, (i == 3), 4'hF, data[32*i +: 32]});
      bus.wready = 1'b1;
      @(negedge clk);
      bus.wready = 1'b0;
    end
    chk("b_wait", {bus.bready, bus.wvalid}, 2'b10);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk("b_hold", {bus.bready, bus.axi_Wdone}, 3'b100);
    end
    bus.bvalid = 1'b1;
    bus.bresp  = bresp;
    bus.bid    = 4'($urandom);
    #1;
    chk("wdone", {bus.axi_Wdone, bus.req_ready}, {exp_done, 1'b0});
    @(negedge clk);
    bus.bvalid = 1'b0;
    #1;
    chk("wdone_end", {bus.axi_Wdone, bus.req_ready}, 3'b001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_addr = 0; bus.write_en = 0; bus.req_Wdata = 0; bus.res_ready = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;

    vecs[0] = '{we:0, addr:32'h1C00_0014, wdata:'0,
                rbeats:128'h00000044_00000033_00000022_00000011, nbeats:4, last_final:1,
                bresp:0, dly:2, exp_addr:32'h1C00_0010,
                exp_rdata:128'h00000044_00000033_00000022_00000011, exp_done:0};
    vecs[1] = '{we:1, addr:32'h2000_003C, wdata:128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000,
                rbeats:'0, nbeats:4, last_final:1, bresp:2'b00, dly:0, exp_addr:32'h2000_0030,
                exp_rdata:'0, exp_done:2'b01};
    vecs[2] = '{we:1, addr:32'h0000_1238, wdata:128'h01234567_89ABCDEF_FEDCBA98_76543210,
                rbeats:'0, nbeats:4, last_final:1, bresp:2'b00, dly:5, exp_addr:32'h0000_1230,
                exp_rdata:'0, exp_done:2'b01};
    vecs[3] = '{we:0, addr:32'hFFFF_FFFF, wdata:'0,
                rbeats:128'hCAFEF00D_DEADBEEF_5A5A5A5A_A5A5A5A5, nbeats:4, last_final:1,
                bresp:0, dly:5, exp_addr:32'hFFFF_FFF0,
                exp_rdata:128'hCAFEF00D_DEADBEEF_5A5A5A5A_A5A5A5A5, exp_done:0};
    vecs[4] = '{we:0, addr:32'h0000_0004, wdata:'0,
                rbeats:128'h99999999_88888888_BBBB2222_AAAA1111, nbeats:2, last_final:1,
                bresp:0, dly:1, exp_addr:32'h0000_0000,
                exp_rdata:128'h00000000_00000000_BBBB2222_AAAA1111, exp_done:0};
    vecs[5] = '{we:0, addr:32'h8000_0120, wdata:'0,
                rbeats:128'h44443333_22221111_FFFFEEEE_DDDDCCCC, nbeats:4, last_final:0,
                bresp:0, dly:0, exp_addr:32'h8000_0120,
                exp_rdata:128'h44443333_22221111_FFFFEEEE_DDDDCCCC, exp_done:0};
    vecs[6] = '{we:1, addr:32'h0BAD_F00F, wdata:128'h00000004_00000003_00000002_00000001,
                rbeats:'0, nbeats:4, last_final:1, bresp:2'b11, dly:1, exp_addr:32'h0BAD_F000,
                exp_rdata:'0, exp_done:2'b11};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_outputs", {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready,
                        bus.res_valid, bus.axi_Wdone, bus.req_ready}, '0);
    chk("rst_rdata", bus.res_Rdata, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", {bus.req_ready, bus.arvalid, bus.awvalid, bus.axi_Wdone}, 5'b10000);

    // Directed vector table
    foreach (vecs[k]) begin
      if (vecs[k].we)
        run_wb(vecs[k].addr, vecs[k].wdata, vecs[k].bresp, vecs[k].dly, vecs[k].exp_addr,
               vecs[k].exp_done, 1'b0, 32'h0);
      else
        run_fill(vecs[k].addr, vecs[k].rbeats, vecs[k].nbeats, vecs[k].last_final, vecs[k].dly,
                 vecs[k].exp_addr, vecs[k].exp_rdata, 1'b0);
    end

    // Dirty miss: write-back with SLVERR, fill request held valid throughout
    run_wb(32'h3000_0048, 128'h11112222_33334444_55556666_77778888, 2'b10, 1,
           32'h3000_0040, 2'b11, 1'b1, 32'h4000_0077);
    run_fill(32'h4000_0077, 128'h0000000D_0000000C_0000000B_0000000A, 4, 1'b1, 0,
             32'h4000_0070, 128'h0000000D_0000000C_0000000B_0000000A, 1'b1);

    // Randomized transactions against the model
    for (int k = 0; k < 24; k++) begin
      bit           we;
      logic [31:0]  a;
      logic [127:0] d;
      int           nb;
      bit           lf;
      logic [1:0]   br;
      int           dl;
      we = 1'($urandom);
      a  = $urandom;
      d  = {$urandom, $urandom, $urandom, $urandom};
      nb = $urandom_range(1, 4);
      lf = 1'($urandom);
      br = 2'($urandom);
      dl = $urandom_range(0, 3);
      if (we)
        run_wb(a, d, br, dl, model_line_addr(a), {br != 2'b00, 1'b1}, 1'b0, 32'h0);
      else
        run_fill(a, d, nb, lf, dl, model_line_addr(a), model_fill(d, nb), 1'b0);
    end

    // Reset during W_DATA beat 2 abandons the write-back
    bus.req_addr  = 32'h5000_0010;
    bus.write_en  = 1'b1;
    bus.req_Wdata = 128'h33333333_22222222_11111111_00000000;
    bus.req_valid = 1'b1;
    begin
      int t;
      wait_accept(t);
    end
    bus.req_valid = 1'b0;
    bus.awready   = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0;
    bus.wready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.wready = 1'b0;
    chk("mid_beat2", {bus.wvalid, bus.wlast, bus.wdata}, {2'b10, 32'h22222222});
    rst = 1'b0;
    #1;
    chk("mid_rst_low", {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready,
                        bus.res_valid, bus.axi_Wdone, bus.req_ready}, '0);
    @(negedge clk);
    chk("mid_rst_edge", {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.axi_Wdone,
                         bus.req_ready}, '0);
    chk("mid_rst_rdata", bus.res_Rdata, '0);
    rst = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b00;
    #1;
    chk("mid_rst_after", {bus.wvalid, bus.bready, bus.axi_Wdone, bus.res_valid, bus.req_ready},
        6'b000001);
    @(negedge clk);
    bus.bvalid = 1'b0;

    // Normal operation resumes after the abandoned burst
    run_fill(32'h6000_0030, 128'h0000FFFF_0000EEEE_0000DDDD_0000CCCC, 3, 1'b1, 0,
             32'h6000_0030, 128'h00000000_0000EEEE_0000DDDD_0000CCCC, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
